// File: rtl/uart_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_pkg : shared state encoding and constants for the UART transmit arbiter
// Revision : 1.0
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int CLK_FREQ             = 50_000_000;
  localparam int BAUD_RATE            = 115_200;
  localparam int HOLD_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, searching from ptr_i+1 upward
// Revision   : 1.0
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  int   best_d;
  int   sel_d;
  logic found_d;

  // Rank each requester by its distance after the pointer; nearest wins.
  always_comb begin
    best_d  = N_REQ;
    sel_d   = 0;
    found_d = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (req_i[j] && (((j + N_REQ - 1 - int'(ptr_i)) % N_REQ) < best_d)) begin
        best_d  = (j + N_REQ - 1 - int'(ptr_i)) % N_REQ;
        sel_d   = j;
        found_d = 1'b1;
      end
    end
    gnt_o = '0;
    for (int j = 0; j < N_REQ; j++) begin
      gnt_o[j] = found_d && (sel_d == j);
    end
    idx_o = IDX_W'(sel_d);
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_tx : 8N1 serial transmitter, one start pulse launches one frame
// Revision: 1.0
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       ready_o
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [9:0]       shift_q;
  logic [3:0]       bit_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '1;
      bit_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (!busy_q) begin
      if (start_i) begin
        shift_q <= {1'b1, data_i, 1'b0};
        bit_q   <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      shift_q <= {1'b1, shift_q[9:1]};
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
      end else begin
        bit_q <= bit_q + 4'd1;
      end
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tx_o    = busy_q ? shift_q[0] : 1'b1;
  assign ready_o = !busy_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_tx_arb : shares one UART transmitter between N_REQ message sources
// Revision    : 1.0
// -----------------------------------------------------------------------------
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               uart_start,
  output logic [7:0]         uart_data,
  input  logic               uart_ready
);

  localparam int               IDX_W     = $clog2(N_REQ);
  localparam int               HOLD_W    = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam bit               HOLD_EN   = (HOLD_TIMEOUT > 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

  arb_state_e        state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]  owner_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic              last_q;
  logic [HOLD_W-1:0] hold_q;
  logic              uart_start_q;
  logic [7:0]        uart_data_q;

  logic [N_REQ-1:0]  arb_gnt_d;
  logic [IDX_W-1:0]  arb_idx_d;
  logic              xfer_d;
  logic [7:0]        owner_byte_d;
  logic [HOLD_W-1:0] hold_d;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt_d),
    .idx_o (arb_idx_d)
  );

  assign req_ready    = (state_q == ST_SEND && uart_ready) ? grant_q : '0;
  assign xfer_d       = req_ready[owner_q] & req_valid[owner_q];
  assign owner_byte_d = req_data[{owner_q, 3'b000} +: 8];
  assign hold_d       = hold_q + HOLD_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= IDX_W'(N_REQ - 1);
      last_q       <= 1'b0;
      hold_q       <= '0;
      uart_start_q <= 1'b0;
      uart_data_q  <= 8'h00;
    end else begin
      uart_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          hold_q <= '0;
          if (|req_valid) begin
            grant_q <= arb_gnt_d;
            owner_q <= arb_idx_d;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (xfer_d) begin
            uart_data_q  <= owner_byte_d;
            uart_start_q <= 1'b1;
            last_q       <= req_last[owner_q];
            hold_q       <= '0;
            state_q      <= ST_WAIT_ACK;
          end else if (HOLD_EN && !req_valid[owner_q]) begin
            // A stalled owner forfeits the line so others are not starved.
            if (hold_q == HOLD_LAST) begin
              grant_q  <= '0;
              rr_ptr_q <= owner_q;
              hold_q   <= '0;
              state_q  <= ST_IDLE;
            end else begin
              hold_q <= hold_d;
            end
          end
        end
        ST_WAIT_ACK: begin
          if (!uart_ready) begin
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (uart_ready) begin
            if (last_q) begin
              grant_q  <= '0;
              rr_ptr_q <= owner_q;
              state_q  <= ST_IDLE;
            end else begin
              state_q <= ST_SEND;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign busy       = (state_q != ST_IDLE);
  assign uart_start = uart_start_q;
  assign uart_data  = uart_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_uart_tx_arb : directed bench for the arbiter driving a 4-clock-per-bit UART
// Revision       : 1.0
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           tx_rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           uart_start;
  logic [7:0]     uart_data;
  logic           uart_ready;
  logic           tx;

  uart_tx_arb #(
    .N_REQ        (N),
    .HOLD_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .grant      (grant),
    .busy       (busy),
    .uart_start (uart_start),
    .uart_data  (uart_data),
    .uart_ready (uart_ready)
  );

  uart_tx #(
    .CLKS_PER_BIT (4)
  ) u_tx (
    .clk     (clk),
    .rst_n   (tx_rst_n),
    .start_i (uart_start),
    .data_i  (uart_data),
    .tx_o    (tx),
    .ready_o (uart_ready)
  );

  int n_checks;
  int n_pass;

  // Per-requester byte queues: bit 8 is the last flag.
  logic [8:0]   fbuf [N][8];
  int           fhead [N];
  int           fcnt  [N];
  logic [N-1:0] xfer_prev;

  logic [7:0]   rx_log [32];
  int           rx_cnt;
  int           rx_bad_stop;
  logic [7:0]   rx_b;
  logic [N-1:0] st_grant [32];
  int           st_cnt;

  initial forever begin
    @(negedge clk);
    if (uart_start === 1'b1) begin
      if (st_cnt < 32) st_grant[st_cnt] = grant;
      st_cnt++;
    end
  end

  // Serial decoder: samples the middle of each 4-clock bit.
  initial forever begin
    @(negedge clk);
    if (tx_rst_n === 1'b1 && tx === 1'b0) begin
      repeat (5) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        rx_b[k] = tx;
        if (k < 7) repeat (4) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      if (tx !== 1'b1) rx_bad_stop++;
      if (rx_cnt < 32) rx_log[rx_cnt] = rx_b;
      rx_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic load(input int i, input logic [8:0] v);
    fbuf[i][fcnt[i]] = v;
    fcnt[i]++;
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (fhead[i] < fcnt[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (xfer_prev[i]) fhead[i]++;
      req_valid[i] = (fhead[i] < fcnt[i]);
      req_data[8*i +: 8] = req_valid[i] ? fbuf[i][fhead[i]][7:0] : 8'h00;
      req_last[i] = req_valid[i] ? fbuf[i][fhead[i]][8] : 1'b0;
    end
    xfer_prev = req_ready & req_valid;
  endtask

  task automatic run_until_idle(input int maxc);
    int c;
    c = 0;
    do begin
      drive_cycle();
      c++;
    end while (!(drained() && !busy && uart_ready) && c < maxc);
    n_checks++; if (c >= maxc) $display("FAIL drain_timeout: got %0d cycles want < %0d", c, maxc); else n_pass++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tx_rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; xfer_prev = '0;
    for (int i = 0; i < N; i++) begin fhead[i] = 0; fcnt[i] = 0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; tx_rst_n = 1'b1;
    rx_cnt = 0; st_cnt = 0; rx_bad_stop = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
    n_checks++; if (uart_start !== 1'b0) $display("FAIL reset_start: got %b want 0", uart_start); else n_pass++;
    n_checks++; if (uart_data !== 8'h00) $display("FAIL reset_data: got %h want 00", uart_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single_byte();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001; req_data[7:0] = 8'hA5; req_last = 4'b0001;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0001) $display("FAIL single_grant_c1: got %b want 0001", grant); else n_pass++;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready_c1: got %b want 0001", req_ready); else n_pass++;
    n_checks++; if (uart_start !== 1'b0) $display("FAIL single_start_c1: got %b want 0", uart_start); else n_pass++;
    @(negedge clk);
    req_valid = '0; req_last = '0;
    n_checks++; if (uart_start !== 1'b1) $display("FAIL single_start_c2: got %b want 1", uart_start); else n_pass++;
    n_checks++; if (uart_data !== 8'hA5) $display("FAIL single_data_c2: got %h want a5", uart_data); else n_pass++;
    repeat (41) @(negedge clk);
    n_checks++; if (grant !== 4'b0001) $display("FAIL single_grant_c43: got %b want 0001", grant); else n_pass++;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0000) $display("FAIL single_grant_c44: got %b want 0000", grant); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_c44: got %b want 0", busy); else n_pass++;
    n_checks++; if (rx_cnt !== 1 || rx_log[0] !== 8'hA5) $display("FAIL single_rx: got cnt %0d byte %h want 1 a5", rx_cnt, rx_log[0]); else n_pass++;
    n_checks++; if (st_cnt !== 1 || rx_bad_stop !== 0) $display("FAIL single_frames: got starts %0d badstop %0d want 1 0", st_cnt, rx_bad_stop); else n_pass++;
  endtask

  task automatic test_contention();
    logic [7:0] exp_b [6];
    exp_b = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
    do_reset();
    load(0, {1'b0, 8'h11}); load(0, {1'b0, 8'h12}); load(0, {1'b1, 8'h13});
    load(2, {1'b0, 8'h21}); load(2, {1'b0, 8'h22}); load(2, {1'b1, 8'h23});
    run_until_idle(1000);
    n_checks++; if (rx_cnt !== 6) $display("FAIL cont_count: got %0d want 6", rx_cnt); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (rx_log[k] !== exp_b[k]) $display("FAIL cont_byte%0d: got %h want %h", k, rx_log[k], exp_b[k]); else n_pass++;
      n_checks++; if (st_grant[k] !== ((k < 3) ? 4'b0001 : 4'b0100)) $display("FAIL cont_grant%0d: got %b want %b", k, st_grant[k], (k < 3) ? 4'b0001 : 4'b0100); else n_pass++;
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] eg;
    logic [7:0]   eb;
    do_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) load(i, {1'b1, 8'h40 + 8'(i * 2 + m)});
    run_until_idle(1500);
    n_checks++; if (st_cnt !== 8) $display("FAIL fair_count: got %0d want 8", st_cnt); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      eg = '0; eg[k % 4] = 1'b1;
      eb = 8'h40 + 8'((k % 4) * 2 + k / 4);
      n_checks++; if (st_grant[k] !== eg) $display("FAIL fair_grant%0d: got %b want %b", k, st_grant[k], eg); else n_pass++;
      n_checks++; if (rx_log[k] !== eb) $display("FAIL fair_byte%0d: got %h want %h", k, rx_log[k], eb); else n_pass++;
    end
  endtask

  task automatic test_stall_timeout();
    int c;
    do_reset();
    load(1, {1'b0, 8'h5A});
    load(3, {1'b1, 8'h77});
    c = 0;
    do begin drive_cycle(); c++; end while (uart_start !== 1'b1 && c < 200);
    do begin drive_cycle(); c++; end while (req_ready[1] !== 1'b1 && c < 200);
    n_checks++; if (c >= 200) $display("FAIL stall_resend_timeout: got %0d cycles want < 200", c); else n_pass++;
    repeat (15) drive_cycle();
    n_checks++; if (grant !== 4'b0010) $display("FAIL stall_grant_15: got %b want 0010", grant); else n_pass++;
    drive_cycle();
    n_checks++; if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL stall_release_16: got grant %b busy %b want 0000 0", grant, busy); else n_pass++;
    drive_cycle();
    n_checks++; if (grant !== 4'b1000) $display("FAIL stall_next_owner: got %b want 1000", grant); else n_pass++;
    run_until_idle(500);
    n_checks++; if (rx_cnt !== 2 || rx_log[0] !== 8'h5A || rx_log[1] !== 8'h77) $display("FAIL stall_rx: got %0d %h %h want 2 5a 77", rx_cnt, rx_log[0], rx_log[1]); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int  c;
    do_reset();
    load(0, {1'b0, 8'h81});
    load(0, {1'b1, 8'h82});
    c = 0;
    do begin drive_cycle(); c++; end while (uart_start !== 1'b1 && c < 200);
    repeat (4) drive_cycle();
    n_checks++; if (busy !== 1'b1 || grant !== 4'b0001) $display("FAIL midrst_pre: got busy %b grant %b want 1 0001", busy, grant); else n_pass++;
    rst_n = 1'b0;
    drive_cycle();
    rst_n = 1'b1;
    n_checks++; if (grant !== 4'b0000) $display("FAIL midrst_grant: got %b want 0000", grant); else n_pass++;
    n_checks++; if (busy !== 1'b0 || uart_start !== 1'b0) $display("FAIL midrst_state: got busy %b start %b want 0 0", busy, uart_start); else n_pass++;
    n_checks++; if (uart_data !== 8'h00) $display("FAIL midrst_data: got %h want 00", uart_data); else n_pass++;
    n_checks++; if (uart_ready !== 1'b0) $display("FAIL midrst_tx_busy: got ready %b want 0", uart_ready); else n_pass++;
    c = 0;
    do begin drive_cycle(); c++; end while (uart_start !== 1'b1 && c < 200);
    n_checks++; if (c >= 200) $display("FAIL midrst_restart_timeout: got %0d cycles want < 200", c); else n_pass++;
    n_checks++; if (rx_cnt !== 1 || rx_log[0] !== 8'h81) $display("FAIL midrst_first_frame: got cnt %0d byte %h want 1 81", rx_cnt, rx_log[0]); else n_pass++;
    n_checks++; if (uart_data !== 8'h82 || grant !== 4'b0001) $display("FAIL midrst_restart: got data %h grant %b want 82 0001", uart_data, grant); else n_pass++;
    run_until_idle(500);
    n_checks++; if (rx_cnt !== 2 || rx_log[1] !== 8'h82 || rx_bad_stop !== 0) $display("FAIL midrst_rx: got cnt %0d byte %h badstop %0d want 2 82 0", rx_cnt, rx_log[1], rx_bad_stop); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; tx_rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; xfer_prev = '0;
    n_checks = 0; n_pass = 0; rx_cnt = 0; st_cnt = 0; rx_bad_stop = 0;
    test_reset();
    test_single_byte();
    test_contention();
    test_fairness();
    test_stall_timeout();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter HOLD_TIMEOUT, default 1024, giving the idle cycles an owner may stall mid-message before losing its grant (0 = never).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, N_REQ bits, where bit i means requester i offers a byte.
REQ-006 The block SHALL have port req_data, input, 8*N_REQ bits, carrying requester i's byte in bits [8i+7:8i].
REQ-007 The block SHALL have port req_last, input, N_REQ bits, where bit i marks the offered byte as the last of its message.
REQ-008 The block SHALL have port req_ready, output, N_REQ bits, where bit i signals that the byte is accepted this cycle.
REQ-009 The block SHALL have port grant, output, N_REQ bits, one-hot for the current owner and zero when no requester owns the UART.
REQ-010 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-011 The block SHALL have port uart_start, output, 1 bit, a single-cycle pulse that launches one UART frame.
REQ-012 The block SHALL have port uart_data, output, 8 bits, holding the byte for the frame and stable while uart_start is high.
REQ-013 The block SHALL have port uart_ready, input, 1 bit, high while the transmitter is idle.

Function
REQ-014 The block SHALL implement states IDLE, SEND, WAIT_ACK and WAIT_DONE.
REQ-015 In IDLE with any req_valid high, the block SHALL register grant to the first valid requester found by searching round-robin from rr_ptr+1 and enter SEND on the next cycle.
REQ-016 In SEND, req_ready[i] SHALL be combinational (state==SEND && grant[i] && uart_ready), and a transfer SHALL occur on any edge where req_ready[i] && req_valid[i].
REQ-017 On a transfer, the block SHALL register uart_data<=byte, uart_start<=1 for exactly the next cycle, and last_q<=req_last[i], then enter WAIT_ACK.
REQ-018 In WAIT_ACK, the block SHALL wait for uart_ready==0 and then enter WAIT_DONE; uart_start SHALL never be reasserted before this point.
REQ-019 In WAIT_DONE, on uart_ready==1 the block SHALL, if last_q is set, clear grant, set rr_ptr to the owner index and enter IDLE; otherwise it SHALL return to SEND with grant held.
REQ-020 The grant SHALL be held for an entire message, and bytes of different requesters SHALL never interleave within a message.
REQ-021 In SEND with the owner's req_valid low, a hold counter SHALL increment; on reaching HOLD_TIMEOUT, the block SHALL drop the grant, set rr_ptr to the owner and enter IDLE; any transfer SHALL clear the counter.
REQ-022 Latency: with the transmitter idle, req_valid rising in cycle 0 SHALL produce grant in cycle 1, the transfer at the end of cycle 1, and uart_start high in cycle 2.
REQ-023 Requests from non-owners SHALL be ignored until the block returns to IDLE; simultaneous requests SHALL resolve by round-robin only.
REQ-024 A requester that drops req_valid while in IDLE arbitration SHALL NOT be granted; grant SHALL be computed from req_valid in the same cycle.
REQ-025 Changes to req_data or req_last by a non-owner, or by the owner outside a transfer cycle, SHALL have no effect.

Reset
REQ-026 While rst_n==0 at an edge, the block SHALL set state=IDLE, grant=0, req_ready=0, uart_start=0, uart_data=8'h00, busy=0, last_q=0, hold counter=0, and rr_ptr=N_REQ-1, so that requester 0 has first priority.
REQ-027 On reset mid-message, the block SHALL drop the grant without further req_ready; any frame already on the line completes in the transmitter, and the next issue SHALL wait for uart_ready==1 in SEND.

Structure
REQ-028 Package uart_pkg SHALL hold the state enumeration, the HOLD_TIMEOUT default and the shared CLK_FREQ/BAUD_RATE constants.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector and pointer; output: one-hot grant and index).
REQ-030 The hold counter width SHALL be $clog2(HOLD_TIMEOUT+1), with a minimum of 1.

Verification
REQ-031 The bench SHALL drive uart_tx with CLKS_PER_BIT=4 and decode tx with a serial monitor.
REQ-032 Single byte: req 0 sends 8'hA5 with last=1 -> grant=0001 in cycle 1, uart_start in cycle 2, tx frame 0,10100101(LSB first),1, grant=0 after stop bit.
REQ-033 Contention: reqs 0 and 2 each send a 3-byte message simultaneously -> all 3 bytes of req 0 on the line, then all 3 of req 2, with no interleave.
REQ-034 Fairness: all 4 reqs continuously send 1-byte messages -> grant order 0,1,2,3,0,1 with no requester starved.
REQ-035 Stall timeout: with HOLD_TIMEOUT=16, req 1 sends 1 byte with last=0 and then drops valid -> grant released exactly 16 cycles after entering SEND, and req 3, waiting, is granted next.
REQ-036 Reset mid-frame: assert rst_n=0 for 1 cycle during WAIT_DONE -> grant=0, no uart_start, and the next message's uart_start only after uart_ready returns high.
